// File: rtl/fetch_stage.sv
// PC register and IF/ID front end: sequential fetch, stall, jump/branch redirect
// with flush, a one-cycle boot bubble after reset, and sticky halt on HALT_WORD.
//
// state  | meaning
// BOOT   | first cycle after reset; PC held, IF/ID bubble, redirects ignored
// RUN    | normal fetch with redirect > stall > halt-word > sequential priority
// HALT   | HALT_WORD fetched; PC frozen, IF/ID bubble until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instruction,
  output logic [31:0] inst_address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;

  logic        redirect;
  logic        halt_fetch;
  logic [31:0] redir_raw;
  logic [31:0] redir_pc;
  logic [31:0] next_pc;

  // Jump outranks branch when both are asserted.
  assign redirect   = jump | branch_taken;
  assign redir_raw  = jump ? jump_target : branch_target;
  assign redir_pc   = {redir_raw[31:2], 2'b00} % MEM_SIZE;
  assign next_pc    = (pc_q + 32'd4) % MEM_SIZE;
  assign halt_fetch = (instruction == HALT_WORD);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (!redirect && !stall && halt_fetch) state_d = S_HALT;
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (redirect) begin
          pc_d    = redir_pc;
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          if (redir_raw[1:0] != 2'b00) mis_d = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_fetch) begin
          instr_d = NOP_WORD;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else begin
          pc_d    = next_pc;
          instr_d = instruction;
          pc4_d   = next_pc;
          valid_d = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        instr_d = NOP_WORD;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_address = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign halted       = (state_q == S_HALT);
  assign misaligned   = mis_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, halt/reset sequence, and
// randomized traffic checked against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] instruction;
  logic [31:0] inst_address, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted, misaligned;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:63];
  assign instruction = mem[inst_address[7:2]];

  fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction),
    .inst_address(inst_address), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_boot, m_halt, m_mis;
  logic [15:0] m_cnt;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_val;
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
  endtask

  // One clock edge of fetch behaviour, given the inputs seen at that edge.
  task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                            input logic jp, input logic [31:0] jt);
    logic [31:0] t;
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      model_bubble();
    end else if (jp || br) begin
      t = jp ? jt : bt;
      if (t[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = (t & ~32'd3) % 32'd256;
      model_bubble();
    end else if (st) begin
      m_pc = m_pc;
    end else if (word == HALT) begin
      m_halt = 1'b1;
      model_bubble();
    end else begin
      m_instr = word;
      m_pc4   = (m_pc + 32'd4) % 32'd256;
      m_valid = 1'b1;
      m_pc    = m_pc4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " pc"},    inst_address, m_pc);
    chk({tag, " instr"}, if_id_instr, m_instr);
    chk({tag, " pc4"},   if_id_pc4, m_pc4);
    chk({tag, " valid"}, 32'(if_id_valid), 32'(m_valid));
    chk({tag, " halted"}, 32'(halted), 32'(m_halt));
    chk({tag, " mis"},   32'(misaligned), 32'(m_mis));
    chk({tag, " cnt"},   32'(fetch_count), 32'(m_cnt));
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    stall = st; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    @(posedge clock);
    #1;
    model_step(st, br, bt, jp, jt);
    check_all("step");
    @(negedge clock);
  endtask

  task automatic mid_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | (i * 4);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;

    //      st    br    bt        jp    jt        pc        instr          pc4      val   mis   cnt
    vt[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h00, NOP,           32'h00, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h04, 32'h11,        32'h04, 1'b1, 1'b0, 16'd1};
    vt[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 1'b0, 16'd2};
    vt[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 1'b0, 16'd2};
    vt[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 1'b0, 16'd2};
    vt[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 1'b0, 16'd2};
    vt[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'h33,        32'h0C, 1'b1, 1'b0, 16'd3};
    vt[7]  = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  32'h40, NOP,           32'h00, 1'b0, 1'b0, 16'd3};
    vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h44, 32'hC000_0040, 32'h44, 1'b1, 1'b0, 16'd4};
    vt[9]  = '{1'b0, 1'b1, 32'h80, 1'b1, 32'h20, 32'h20, NOP,           32'h00, 1'b0, 1'b0, 16'd4};
    vt[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h22, 32'h20, NOP,           32'h00, 1'b0, 1'b1, 16'd4};
    vt[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h24, 32'hC000_0020, 32'h24, 1'b1, 1'b1, 16'd5};
    vt[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hFC, 32'hFC, NOP,           32'h00, 1'b0, 1'b1, 16'd5};
    vt[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h00, 32'hC000_00FC, 32'h00, 1'b1, 1'b1, 16'd6};

    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vt[i].st, vt[i].br, vt[i].bt, vt[i].jp, vt[i].jt);
      chk($sformatf("vec%0d pc", i), inst_address, vt[i].e_pc);
      chk($sformatf("vec%0d instr", i), if_id_instr, vt[i].e_instr);
      chk($sformatf("vec%0d pc4", i), if_id_pc4, vt[i].e_pc4);
      chk($sformatf("vec%0d valid", i), 32'(if_id_valid), 32'(vt[i].e_val));
      chk($sformatf("vec%0d mis", i), 32'(misaligned), 32'(vt[i].e_mis));
      chk($sformatf("vec%0d cnt", i), 32'(fetch_count), 32'(vt[i].e_cnt));
    end

    // Halt word at 0x10: first squashed by a branch, then taken for real.
    mem[4] = HALT;
    mid_reset("halt_rst");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("at_halt_word pc", inst_address, 32'h10);
    step(1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
    chk("halt_squashed halted", 32'(halted), 32'd0);
    chk("halt_squashed pc", inst_address, 32'h30);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt pc", inst_address, 32'h10);
    chk("halt valid", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    chk("halt jump_ignored pc", inst_address, 32'h10);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("halt stall valid", 32'(if_id_valid), 32'd0);
    mid_reset("halt_async_rst");
    chk("post_rst pc", inst_address, 32'h0);
    chk("post_rst halted", 32'(halted), 32'd0);

    // Random traffic with sparse halt words and periodic async resets.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 24) == 0) ? HALT : $urandom();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] bt, jt;
      bt = $urandom(); jt = $urandom();
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
           $urandom_range(0, 9) == 0, jt);
      if (n % 60 == 59) mid_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
